// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-drive and response signals of the ALU op sequencer.
// slave = sequencer side, master = producer/ALU/consumer side.
interface alu_op_sequencer_if #(
  parameter int FIFO_DEPTH = 4
) ();
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [7:0]                    cmd_a;
  logic [7:0]                    cmd_b;
  logic [2:0]                    cmd_op;

  logic                          alu_start;
  logic [7:0]                    alu_a;
  logic [7:0]                    alu_b;
  logic [2:0]                    alu_mode;
  logic [7:0]                    alu_c;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [7:0]                    rsp_data;
  logic [2:0]                    rsp_op;
  logic                          rsp_err;

  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_c, rsp_ready,
    output cmd_ready, alu_start, alu_a, alu_b, alu_mode,
           rsp_valid, rsp_data, rsp_op, rsp_err, fifo_count
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_c, rsp_ready,
    input  cmd_ready, alu_start, alu_a, alu_b, alu_mode,
           rsp_valid, rsp_data, rsp_op, rsp_err, fifo_count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command FIFO + issue FSM feeding an 8-bit ALU and returning tagged results.
// Optional macro ALU_SEQ_DIVZERO_CHECK_EN: answer DIV/MOD by zero locally with 8'hFF and rsp_err.
module alu_op_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset,
  alu_op_sequencer_if.slave   bus
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WCNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam int ENT_W  = 3 + 8 + 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (ALU_LATENCY < 1) begin : g_bad_latency
    $error("ALU_LATENCY must be >= 1");
  end

  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_r;

  logic [1:0]        state;
  logic [WCNT_W-1:0] wait_cnt;

  logic [7:0]        alu_a_r;
  logic [7:0]        alu_b_r;
  logic [2:0]        alu_mode_r;
  logic              rsp_valid_r;
  logic [7:0]        rsp_data_r;
  logic [2:0]        rsp_op_r;

  logic              cmd_ready;
  logic              push;
  logic              pop;
  logic              fifo_nempty;
  logic              accept;
  logic              head_divzero;
  logic [2:0]        head_op;
  logic [7:0]        head_a;
  logic [7:0]        head_b;

  assign cmd_ready   = (count_r < CNT_W'(FIFO_DEPTH));
  assign push        = bus.cmd_valid && cmd_ready;
  assign fifo_nempty = (count_r != '0);
  assign accept      = (state == S_RESP) && rsp_valid_r && bus.rsp_ready;
  // Pop from IDLE, or straight out of RESP on the accept cycle for back-to-back issue.
  assign pop         = fifo_nempty && ((state == S_IDLE) || accept);
  assign {head_op, head_a, head_b} = fifo_mem[rd_ptr];

  // ---- command FIFO ----
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
  function automatic logic is_divzero(input logic [2:0] op, input logic [7:0] b);
    return ((op == OP_DIV) || (op == OP_MOD)) && (b == 8'h00);
  endfunction

  logic rsp_err_r;

  assign head_divzero = is_divzero(head_op, head_b);
  assign bus.rsp_err  = rsp_err_r;

  // Error flag belongs to whichever command was popped last.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_err_r <= 1'b0;
    end else if (pop) begin
      rsp_err_r <= head_divzero;
    end
  end
`else
  assign head_divzero = 1'b0;
  assign bus.rsp_err  = 1'b0;
`endif

  // ---- issue / wait / respond FSM ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      alu_a_r     <= 8'h00;
      alu_b_r     <= 8'h00;
      alu_mode_r  <= OP_ADD;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'h00;
      rsp_op_r    <= OP_ADD;
    end else begin
      case (state)
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == WCNT_W'(ALU_LATENCY - 1)) begin
            rsp_data_r  <= bus.alu_c;
            rsp_op_r    <= alu_mode_r;
            rsp_valid_r <= 1'b1;
            state       <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        S_RESP: begin
          if (accept) begin
            rsp_valid_r <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: ;
      endcase

      // A pop overrides the IDLE fall-back chosen above on the accept cycle.
      if (pop) begin
        if (head_divzero) begin
          rsp_data_r  <= 8'hFF;
          rsp_op_r    <= head_op;
          rsp_valid_r <= 1'b1;
          state       <= S_RESP;
        end else begin
          alu_a_r    <= head_a;
          alu_b_r    <= head_b;
          alu_mode_r <= head_op;
          state      <= S_ISSUE;
        end
      end
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.fifo_count = count_r;
  assign bus.alu_start  = (state == S_ISSUE);
  assign bus.alu_a      = alu_a_r;
  assign bus.alu_b      = alu_b_r;
  assign bus.alu_mode   = alu_mode_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_data   = rsp_data_r;
  assign bus.rsp_op     = rsp_op_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 8-bit ALU on the issue lines.
module tb_alu_op_sequencer;

  localparam int FIFO_DEPTH  = 4;
  localparam int ALU_LATENCY = 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   starts = 0;

  always #5 clock = ~clock;

  alu_op_sequencer_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  alu_op_sequencer #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .ALU_LATENCY (ALU_LATENCY)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.alu_start === 1'b1) starts <= starts + 1;
  end

  // Simple ALU: operands are held by the sequencer, so a combinational model suits any latency.
  always_comb begin
    bus.alu_c = 8'h00;
    case (bus.alu_mode)
      OP_ADD:  bus.alu_c = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_c = bus.alu_a - bus.alu_b;
      OP_MUL:  bus.alu_c = bus.alu_a * bus.alu_b;
      OP_DIV:  bus.alu_c = (bus.alu_b == 8'h00) ? 8'hFF : bus.alu_a / bus.alu_b;
      OP_MOD:  bus.alu_c = (bus.alu_b == 8'h00) ? bus.alu_a : bus.alu_a % bus.alu_b;
      default: bus.alu_c = 8'h00;
    endcase
  end

  task automatic drive_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_a = 8'h00; bus.cmd_b = 8'h00; bus.cmd_op = OP_ADD;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clock);
    n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready got=%0h exp=1", bus.cmd_ready); end
    n_vec++; if (bus.alu_start !== 1'b0) begin n_err++; $display("FAIL rst_alu_start got=%0h exp=0", bus.alu_start); end
    n_vec++; if (bus.alu_a !== 8'h00) begin n_err++; $display("FAIL rst_alu_a got=%0h exp=0", bus.alu_a); end
    n_vec++; if (bus.alu_b !== 8'h00) begin n_err++; $display("FAIL rst_alu_b got=%0h exp=0", bus.alu_b); end
    n_vec++; if (bus.alu_mode !== OP_ADD) begin n_err++; $display("FAIL rst_alu_mode got=%0h exp=%0h", bus.alu_mode, OP_ADD); end
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got=%0h exp=0", bus.rsp_valid); end
    n_vec++; if (bus.rsp_data !== 8'h00) begin n_err++; $display("FAIL rst_rsp_data got=%0h exp=0", bus.rsp_data); end
    n_vec++; if (bus.rsp_op !== OP_ADD) begin n_err++; $display("FAIL rst_rsp_op got=%0h exp=%0h", bus.rsp_op, OP_ADD); end
    n_vec++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL rst_rsp_err got=%0h exp=0", bus.rsp_err); end
    n_vec++; if (bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL rst_fifo_count got=%0d exp=0", bus.fifo_count); end
    reset = 1'b0;
    @(negedge clock);
    n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready got=%0h exp=1", bus.cmd_ready); end
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_valid got=%0h exp=0", bus.rsp_valid); end
  endtask

  task automatic test_single_op();
    int s0;
    bus.rsp_ready = 1'b1;
    s0 = starts;
    drive_cmd(OP_ADD, 8'h12, 8'h34);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    n_vec++; if (bus.fifo_count !== 3'd1) begin n_err++; $display("FAIL single_count_c1 got=%0d exp=1", bus.fifo_count); end
    n_vec++; if (bus.alu_start !== 1'b0) begin n_err++; $display("FAIL single_start_c1 got=%0h exp=0", bus.alu_start); end
    @(negedge clock);
    n_vec++; if (bus.alu_start !== 1'b1) begin n_err++; $display("FAIL single_start_c2 got=%0h exp=1", bus.alu_start); end
    n_vec++; if (bus.alu_a !== 8'h12) begin n_err++; $display("FAIL single_alu_a got=%0h exp=12", bus.alu_a); end
    n_vec++; if (bus.alu_b !== 8'h34) begin n_err++; $display("FAIL single_alu_b got=%0h exp=34", bus.alu_b); end
    n_vec++; if (bus.alu_mode !== OP_ADD) begin n_err++; $display("FAIL single_alu_mode got=%0h exp=%0h", bus.alu_mode, OP_ADD); end
    n_vec++; if (bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL single_count_c2 got=%0d exp=0", bus.fifo_count); end
    @(negedge clock);
    n_vec++; if (bus.alu_start !== 1'b0) begin n_err++; $display("FAIL single_start_c3 got=%0h exp=0", bus.alu_start); end
    repeat (ALU_LATENCY - 1) @(negedge clock);
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_early got=%0h exp=0", bus.rsp_valid); end
    @(negedge clock);
    n_vec++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%0h exp=1", bus.rsp_valid); end
    n_vec++; if (bus.rsp_data !== 8'h46) begin n_err++; $display("FAIL single_data got=%0h exp=46", bus.rsp_data); end
    n_vec++; if (bus.rsp_op !== OP_ADD) begin n_err++; $display("FAIL single_op got=%0h exp=%0h", bus.rsp_op, OP_ADD); end
    n_vec++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL single_err got=%0h exp=0", bus.rsp_err); end
    @(negedge clock);
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_after got=%0h exp=0", bus.rsp_valid); end
    n_vec++; if (starts - s0 !== 1) begin n_err++; $display("FAIL single_starts got=%0d exp=1", starts - s0); end
  endtask

  task automatic test_fill();
    logic [2:0] f_op [5];
    logic [7:0] f_a  [5];
    logic [7:0] f_b  [5];
    logic [7:0] f_r  [5];
    int s0;
    f_op = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD};
    f_a  = '{8'h01, 8'h0A, 8'h03, 8'h64, 8'h64};
    f_b  = '{8'h02, 8'h03, 8'h04, 8'h07, 8'h07};
    f_r  = '{8'h03, 8'h07, 8'h0C, 8'h0E, 8'h02};
    bus.rsp_ready = 1'b0;
    s0 = starts;
    for (int i = 0; i < 5; i++) begin
      drive_cmd(f_op[i], f_a[i], f_b[i]);
      n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_%0d got=%0h exp=1", i, bus.cmd_ready); end
      @(negedge clock);
    end
    drive_cmd(OP_ADD, 8'hAA, 8'h11);
    n_vec++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%0h exp=0", bus.cmd_ready); end
    n_vec++; if (bus.fifo_count !== 3'd4) begin n_err++; $display("FAIL full_count got=%0d exp=4", bus.fifo_count); end
    repeat (2) @(negedge clock);
    bus.cmd_valid = 1'b0;
    n_vec++; if (bus.fifo_count !== 3'd4) begin n_err++; $display("FAIL full_count_hold got=%0d exp=4", bus.fifo_count); end
    for (int w = 0; w < 20 && bus.rsp_valid !== 1'b1; w++) @(negedge clock);
    n_vec++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL fill_parked_valid got=%0h exp=1", bus.rsp_valid); end
    n_vec++; if (bus.rsp_data !== 8'h03) begin n_err++; $display("FAIL fill_parked_data got=%0h exp=03", bus.rsp_data); end
    n_vec++; if (starts - s0 !== 1) begin n_err++; $display("FAIL fill_starts got=%0d exp=1", starts - s0); end
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int w = 0; w < 20 && bus.rsp_valid !== 1'b1; w++) @(negedge clock);
      n_vec++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL drain_timeout_%0d got=%0h exp=1", k, bus.rsp_valid); end
      n_vec++; if (bus.rsp_data !== f_r[k]) begin n_err++; $display("FAIL drain_data_%0d got=%0h exp=%0h", k, bus.rsp_data, f_r[k]); end
      n_vec++; if (bus.rsp_op !== f_op[k]) begin n_err++; $display("FAIL drain_op_%0d got=%0h exp=%0h", k, bus.rsp_op, f_op[k]); end
      @(negedge clock);
    end
    repeat (8) @(negedge clock);
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL drain_no_extra got=%0h exp=0", bus.rsp_valid); end
    n_vec++; if (bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL drain_count got=%0d exp=0", bus.fifo_count); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] b_op [3];
    logic [7:0] b_a  [3];
    logic [7:0] b_b  [3];
    logic [7:0] b_r  [3];
    int s0;
    int prev;
    b_op = '{OP_SUB, OP_MUL, OP_MOD};
    b_a  = '{8'd5, 8'd16, 8'd200};
    b_b  = '{8'd7, 8'd17, 8'd7};
    b_r  = '{8'hFE, 8'h10, 8'h04};
    bus.rsp_ready = 1'b1;
    s0 = starts;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(b_op[i], b_a[i], b_b[i]);
      @(negedge clock);
    end
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 20 && bus.rsp_valid !== 1'b1; w++) @(negedge clock);
      n_vec++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_timeout_%0d got=%0h exp=1", k, bus.rsp_valid); end
      n_vec++; if (bus.rsp_data !== b_r[k]) begin n_err++; $display("FAIL b2b_data_%0d got=%0h exp=%0h", k, bus.rsp_data, b_r[k]); end
      n_vec++; if (bus.rsp_op !== b_op[k]) begin n_err++; $display("FAIL b2b_op_%0d got=%0h exp=%0h", k, bus.rsp_op, b_op[k]); end
      if (k > 0) begin
        n_vec++; if (cyc - prev !== ALU_LATENCY + 2) begin n_err++; $display("FAIL b2b_gap_%0d got=%0d exp=%0d", k, cyc - prev, ALU_LATENCY + 2); end
      end
      prev = cyc;
      @(negedge clock);
    end
    n_vec++; if (starts - s0 !== 3) begin n_err++; $display("FAIL b2b_starts got=%0d exp=3", starts - s0); end
  endtask

  task automatic test_backpressure();
    int s0;
    bus.rsp_ready = 1'b0;
    s0 = starts;
    drive_cmd(OP_ADD, 8'h20, 8'h05);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    for (int w = 0; w < 20 && bus.rsp_valid !== 1'b1; w++) @(negedge clock);
    drive_cmd(OP_MUL, 8'h03, 8'h05);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_%0d got=%0h exp=1", i, bus.rsp_valid); end
      n_vec++; if (bus.rsp_data !== 8'h25) begin n_err++; $display("FAIL bp_data_%0d got=%0h exp=25", i, bus.rsp_data); end
      n_vec++; if (bus.rsp_op !== OP_ADD) begin n_err++; $display("FAIL bp_op_%0d got=%0h exp=%0h", i, bus.rsp_op, OP_ADD); end
      n_vec++; if (bus.alu_a !== 8'h20) begin n_err++; $display("FAIL bp_alu_a_%0d got=%0h exp=20", i, bus.alu_a); end
      n_vec++; if (bus.alu_b !== 8'h05) begin n_err++; $display("FAIL bp_alu_b_%0d got=%0h exp=05", i, bus.alu_b); end
      n_vec++; if (bus.alu_start !== 1'b0) begin n_err++; $display("FAIL bp_start_%0d got=%0h exp=0", i, bus.alu_start); end
      @(negedge clock);
    end
    n_vec++; if (bus.fifo_count !== 3'd1) begin n_err++; $display("FAIL bp_count got=%0d exp=1", bus.fifo_count); end
    n_vec++; if (starts - s0 !== 1) begin n_err++; $display("FAIL bp_starts got=%0d exp=1", starts - s0); end
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    for (int w = 0; w < 20 && bus.rsp_valid !== 1'b1; w++) @(negedge clock);
    n_vec++; if (bus.rsp_data !== 8'h0F) begin n_err++; $display("FAIL bp_next_data got=%0h exp=0f", bus.rsp_data); end
    n_vec++; if (bus.rsp_op !== OP_MUL) begin n_err++; $display("FAIL bp_next_op got=%0h exp=%0h", bus.rsp_op, OP_MUL); end
    @(negedge clock);
    n_vec++; if (starts - s0 !== 2) begin n_err++; $display("FAIL bp_starts_end got=%0d exp=2", starts - s0); end
  endtask

  task automatic test_divzero();
    int s0;
    int t0;
    int lat;
    bus.rsp_ready = 1'b1;
    s0 = starts;
    t0 = cyc;
    drive_cmd(OP_DIV, 8'd9, 8'd0);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    for (int w = 0; w < 20 && bus.rsp_valid !== 1'b1; w++) @(negedge clock);
    lat = cyc - t0;
    n_vec++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL dz_valid got=%0h exp=1", bus.rsp_valid); end
    n_vec++; if (bus.rsp_data !== 8'hFF) begin n_err++; $display("FAIL dz_data got=%0h exp=ff", bus.rsp_data); end
    n_vec++; if (bus.rsp_op !== OP_DIV) begin n_err++; $display("FAIL dz_op got=%0h exp=%0h", bus.rsp_op, OP_DIV); end
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    n_vec++; if (bus.rsp_err !== 1'b1) begin n_err++; $display("FAIL dz_err got=%0h exp=1", bus.rsp_err); end
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL dz_latency got=%0d exp=2", lat); end
    n_vec++; if (starts - s0 !== 0) begin n_err++; $display("FAIL dz_starts got=%0d exp=0", starts - s0); end
`else
    n_vec++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL dz_err got=%0h exp=0", bus.rsp_err); end
    n_vec++; if (lat !== 3 + ALU_LATENCY) begin n_err++; $display("FAIL dz_latency got=%0d exp=%0d", lat, 3 + ALU_LATENCY); end
    n_vec++; if (starts - s0 !== 1) begin n_err++; $display("FAIL dz_starts got=%0d exp=1", starts - s0); end
`endif
    @(negedge clock);
    drive_cmd(OP_DIV, 8'd9, 8'd3);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    for (int w = 0; w < 20 && bus.rsp_valid !== 1'b1; w++) @(negedge clock);
    n_vec++; if (bus.rsp_data !== 8'h03) begin n_err++; $display("FAIL div_data got=%0h exp=03", bus.rsp_data); end
    n_vec++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL div_err got=%0h exp=0", bus.rsp_err); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int s0;
    logic seen;
    bus.rsp_ready = 1'b1;
    drive_cmd(OP_ADD, 8'h01, 8'h01);
    @(negedge clock);
    drive_cmd(OP_ADD, 8'h02, 8'h02);
    @(negedge clock);
    drive_cmd(OP_ADD, 8'h03, 8'h03);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    n_vec++; if (bus.fifo_count !== 3'd2) begin n_err++; $display("FAIL mid_pre_count got=%0d exp=2", bus.fifo_count); end
    reset = 1'b1;
    @(negedge clock);
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got=%0h exp=0", bus.rsp_valid); end
    n_vec++; if (bus.fifo_count !== 3'd0) begin n_err++; $display("FAIL mid_count got=%0d exp=0", bus.fifo_count); end
    n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got=%0h exp=1", bus.cmd_ready); end
    reset = 1'b0;
    s0 = starts;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_stale_rsp got=%0h exp=0", seen); end
    n_vec++; if (starts - s0 !== 0) begin n_err++; $display("FAIL mid_starts got=%0d exp=0", starts - s0); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_fill();
    test_back_to_back();
    test_backpressure();
    test_divzero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
